cg_win_proc: RTL and testbench

//  Parametrised clock-gated image window processor. Loads an IMG x IMG signed frame plus an
//  NOP-long op list, applies the ops to a movable WIN x WIN window, streams the window raster.

---
 rtl/cg_win_proc_pkg.sv | 29 ++
 rtl/cg_win_proc_icg.sv | 14 +
 rtl/cg_win_proc.sv | 141 ++++++++++++++
 tb/tb_cg_win_proc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cg_win_proc_pkg.sv
// cg_win_proc_pkg: shared op/state encodings and saturating pixel helpers for cg_win_proc
package cg_win_proc_pkg;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_RIGHT = 4'd1,
    OP_LEFT  = 4'd2,
    OP_UP    = 4'd3,
    OP_DOWN  = 4'd4,
    OP_NEG   = 4'd5,
    OP_ABS   = 4'd6,
    OP_HALF  = 4'd7
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT} state_e;
  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  function automatic int sat(int v, int dw);
    return clamp(v, -(1 << (dw - 1)), (1 << (dw - 1)) - 1);
  endfunction
  function automatic int sat_neg(int v, int dw);
    return sat(-v, dw);
  endfunction
  function automatic int sat_abs(int v, int dw);
    return sat(v < 0 ? -v : v, dw);
  endfunction
  function automatic int half(int v);
    return v >>> 1;
  endfunction
endpackage

// File: rtl/cg_win_proc_icg.sv
// cg_win_proc_icg: latch-based integrated clock gate; gclk follows clk when (en | ~cg_en)
// Ports: clk (free-running clock), en (bank write request), cg_en (gating enable), gclk (gated clock).
module cg_win_proc_icg (
  input  logic clk,
  input  logic en,
  input  logic cg_en,
  output logic gclk
);
  logic en_l;
  always_latch begin
    if (!clk) en_l <= en | ~cg_en;
  end
  assign gclk = clk & en_l;
endmodule

// File: rtl/cg_win_proc.sv
// cg_win_proc: loads an IMG x IMG signed frame plus NOP ops, applies them to a WIN x WIN window, streams the window
// Ports: clk; rst_n (async assert, sync release, active low); cg_en (clock-gating enable, functionally transparent);
//   in_valid/in_data/op (raster frame load, ops on the first NOP load cycles); out_valid/out_data (window raster).
// CG_WIN_PROC_CLKGATE_EN: frame rows live in banks clocked through cg_win_proc_icg; otherwise cg_en is ignored.
module cg_win_proc
  import cg_win_proc_pkg::*;
#(
  parameter int DW  = 7,
  parameter int IMG = 8,
  parameter int WIN = 4,
  parameter int NOP = 15,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cg_en,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  output logic [DW-1:0]  out_data
);
  localparam int CW   = $clog2(IMG * IMG + 1);
  localparam int PW   = IMG > 1 ? $clog2(IMG) : 1;
  localparam int OIW  = NOP > 1 ? $clog2(NOP) : 1;
  localparam int MAXC = IMG - WIN;
  state_e state;
  logic [1:0] rst_sr;
  logic rst_i;
  logic [CW-1:0] cnt;
  logic [PW-1:0] row, col, orow, ocol, ri, ci;
  logic [OPW-1:0] ops [NOP];
  logic [OPW-1:0] cur_op;
  logic cap, exec, is_px, last_o;
  logic [IMG-1:0][IMG-1:0] we;
  logic [IMG-1:0][IMG-1:0][DW-1:0] wd, frame;
  int pv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sr <= '0;
    else rst_sr <= {rst_sr[0], 1'b1};
  end
  assign rst_i  = rst_sr[1];
  assign cap    = in_valid && (state == S_IDLE || state == S_LOAD);
  assign exec   = state == S_EXEC;
  assign cur_op = ops[cnt[OIW-1:0]];
  assign is_px  = exec && (cur_op == OPW'(OP_NEG) || cur_op == OPW'(OP_ABS) || cur_op == OPW'(OP_HALF));
  assign ri     = row + orow;
  assign ci     = col + ocol;
  assign last_o = orow == PW'(WIN - 1) && ocol == PW'(WIN - 1);
  // cnt is 0 in IDLE, so it addresses the pixel being captured in both IDLE and LOAD
  always_comb begin
    we = '0;
    wd = '0;
    pv = 0;
    for (int r = 0; r < IMG; r++) begin
      for (int c = 0; c < IMG; c++) begin
        pv = int'($signed(frame[r][c]));
        we[r][c] = cap ? cnt == CW'(r * IMG + c)
                       : is_px && r >= int'(row) && r < int'(row) + WIN && c >= int'(col) && c < int'(col) + WIN;
        wd[r][c] = cap ? in_data
                       : DW'(cur_op == OPW'(OP_NEG) ? sat_neg(pv, DW) : cur_op == OPW'(OP_ABS) ? sat_abs(pv, DW) : half(pv));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (cap && cnt < CW'(NOP)) ops[cnt[OIW-1:0]] <= op;
  end
  for (genvar r = 0; r < IMG; r++) begin : g_bank
    logic bclk;
    logic [IMG-1:0][DW-1:0] q;
`ifdef CG_WIN_PROC_CLKGATE_EN
    cg_win_proc_icg u_icg (
      .clk   (clk),
      .en    (|we[r]),
      .cg_en (cg_en),
      .gclk  (bclk)
    );
`else
    assign bclk = clk;
`endif
    always_ff @(posedge bclk) begin
      for (int c = 0; c < IMG; c++) if (we[r][c]) q[c] <= wd[r][c];
    end
    assign frame[r] = q;
  end
`ifndef CG_WIN_PROC_CLKGATE_EN
  logic unused_cg;
  assign unused_cg = cg_en;
`endif
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      orow      <= '0;
      ocol      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= state == S_OUT;
      out_data  <= state == S_OUT ? frame[ri][ci] : '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_LOAD;
            cnt   <= CW'(1);
            row   <= '0;
            col   <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) cnt <= cnt + 1'b1;
          if (!in_valid || cnt == CW'(IMG * IMG - 1)) begin
            state <= S_EXEC;
            cnt   <= '0;
          end
        end
        S_EXEC: begin
          col <= cur_op == OPW'(OP_RIGHT) ? PW'(clamp(int'(col) + 1, 0, MAXC)) :
                 cur_op == OPW'(OP_LEFT)  ? PW'(clamp(int'(col) - 1, 0, MAXC)) : col;
          row <= cur_op == OPW'(OP_DOWN)  ? PW'(clamp(int'(row) + 1, 0, MAXC)) :
                 cur_op == OPW'(OP_UP)    ? PW'(clamp(int'(row) - 1, 0, MAXC)) : row;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NOP - 1)) begin
            state <= S_OUT;
            cnt   <= '0;
            orow  <= '0;
            ocol  <= '0;
          end
        end
        S_OUT: begin
          ocol <= ocol == PW'(WIN - 1) ? '0 : ocol + 1'b1;
          orow <= ocol == PW'(WIN - 1) ? orow + 1'b1 : orow;
          if (last_o) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cg_win_proc.sv
// tb_cg_win_proc: scoreboard bench for cg_win_proc with directed and randomized frames
module tb_cg_win_proc;
  localparam int DW  = 7;
  localparam int IMG = 8;
  localparam int WIN = 4;
  localparam int NOP = 15;
  localparam int OPW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cg_en = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [OPW-1:0] op = '0;
  logic out_valid;
  logic signed [DW-1:0] out_data;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int pix[IMG*IMG];
  int opl[NOP];
  int run = 0;
  cg_win_proc #(.DW(DW), .IMG(IMG), .WIN(WIN), .NOP(NOP), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cg_en     (cg_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .op        (op),
    .out_valid (out_valid),
    .out_data  (out_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int op_px(input int o, input int v);
    int lim = (1 << (DW - 1)) - 1;
    int n = o == 5 ? -v : o == 6 ? (v < 0 ? -v : v) : (v >= 0 ? v / 2 : -((1 - v) / 2));
    return n > lim ? lim : n;
  endfunction
  task automatic push_expected();
    int f[IMG][IMG];
    int r = 0;
    int c = 0;
    for (int i = 0; i < IMG * IMG; i++) f[i / IMG][i % IMG] = pix[i];
    for (int k = 0; k < NOP; k++) begin
      case (opl[k])
        1: if (c < IMG - WIN) c++;
        2: if (c > 0) c--;
        3: if (r > 0) r--;
        4: if (r < IMG - WIN) r++;
        5, 6, 7: for (int i = 0; i < WIN; i++) for (int j = 0; j < WIN; j++) f[r+i][c+j] = op_px(opl[k], f[r+i][c+j]);
        default: ;
      endcase
    end
    for (int i = 0; i < WIN; i++) for (int j = 0; j < WIN; j++) exp_q.push_back(f[r+i][c+j]);
  endtask
  task automatic drive_frame();
    push_expected();
    for (int i = 0; i < IMG * IMG; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(pix[i]);
      op       = i < NOP ? OPW'(opl[i]) : OPW'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    op       = OPW'($urandom);
  endtask
  task automatic check_latency();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, NOP + 1);
  endtask
  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d outputs pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic run_frame();
    drive_frame();
    check_latency();
    wait_done();
  endtask
  task automatic ramp();
    for (int i = 0; i < IMG * IMG; i++) pix[i] = i - 32;
  endtask
  task automatic fill(input int v);
    for (int i = 0; i < IMG * IMG; i++) pix[i] = v;
  endtask
  task automatic clear_ops();
    for (int k = 0; k < NOP; k++) opl[k] = 0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) run = 0;
      else if (out_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_output: got %0d, expected no output", out_data);
        end else chk("out_data", int'(out_data), exp_q.pop_front());
      end else begin
        if (run != 0) chk("burst_len", run, WIN * WIN);
        run = 0;
        chk("idle_zero", int'(out_data), 0);
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cg_en = 1'($urandom_range(0, 1));
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ramp(); clear_ops(); run_frame();
    ramp(); clear_ops();
    for (int k = 0; k < 6; k++) opl[k] = 1;
    opl[6] = 4;
    run_frame();
    ramp(); clear_ops(); opl[0] = 4; opl[1] = 4; opl[2] = 5; run_frame();
    fill(-64); clear_ops(); opl[0] = 5; opl[1] = 6; run_frame();
    fill(-5); clear_ops(); opl[0] = 7; run_frame();
    ramp(); clear_ops(); opl[3] = 1; opl[5] = 6;
    drive_frame();
    check_latency();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midout_rst_valid", int'(out_valid), 0);
    chk("midout_rst_data", int'(out_data), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ramp(); clear_ops(); opl[0] = 4; opl[1] = 1; opl[2] = 7; run_frame();
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < IMG * IMG; i++) pix[i] = int'($urandom_range(0, 127)) - 64;
      for (int k = 0; k < NOP; k++) opl[k] = int'($urandom_range(0, 15));
      run_frame();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
